// File: rtl/service_arbiter_if.sv
// Bundle of service-side requests, display words and the arbitrated display/button outputs.
// master drives requests and words; slave is the arbiter itself.
interface service_arbiter_if;
  logic        tick;
  logic [2:0]  spdt;
  logic        push_m;
  logic [15:0] num1;
  logic [15:0] num2;
  logic [15:0] num3;
  logic [2:0]  grant;
  logic [2:0]  push_out;
  logic [3:0]  anode;
  logic [3:0]  digit;

  modport master (
    output tick, spdt, push_m, num1, num2, num3,
    input  grant, push_out, anode, digit
  );

  modport slave (
    input  tick, spdt, push_m, num1, num2, num3,
    output grant, push_out, anode, digit
  );
endinterface

// File: rtl/service_arbiter.sv
// Arbitrates one 4-digit display and one push button between three services with fixed
// priority, no pre-emption, and a 4-tick blanked guard period before each hand-over.
module service_arbiter (
  input logic              clk,
  input logic              reset,
  service_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StActive, StGuard} state_e;

  state_e      state_q, state_d;
  logic [2:0]  owner_q, owner_d;
  logic [1:0]  gcnt_q, gcnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  anode_q, anode_d;
  logic [3:0]  digit_q, digit_d;
  logic [2:0]  push_out_q, push_out_d;

  logic [2:0]  spdt_meta_q, spdt_s_q;
  logic        push_meta_q, push_s_q, push_prev_q;
  logic        push_rise;
  logic [15:0] src_word;

  function automatic logic [2:0] lowest(input logic [2:0] v);
    if (v[0])      return 3'b001;
    else if (v[1]) return 3'b010;
    else if (v[2]) return 3'b100;
    else           return 3'b000;
  endfunction

  // Two-flop synchronizers plus one extra stage of button history for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      spdt_meta_q <= 3'b000;
      spdt_s_q    <= 3'b000;
      push_meta_q <= 1'b0;
      push_s_q    <= 1'b0;
      push_prev_q <= 1'b0;
    end else begin
      spdt_meta_q <= bus.spdt;
      spdt_s_q    <= spdt_meta_q;
      push_meta_q <= bus.push_m;
      push_s_q    <= push_meta_q;
      push_prev_q <= push_s_q;
    end
  end

  assign push_rise = push_s_q & ~push_prev_q;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    gcnt_d  = gcnt_q;
    unique case (state_q)
      StIdle: begin
        if (spdt_s_q != 3'b000) begin
          state_d = StGuard;
          owner_d = lowest(spdt_s_q);
          gcnt_d  = 2'd0;
        end
      end
      StActive, StGuard: begin
        if ((spdt_s_q & owner_q) == 3'b000) begin
          // Owner (or pending owner) withdrew: re-evaluate and restart the guard.
          gcnt_d = 2'd0;
          if (spdt_s_q != 3'b000) begin
            state_d = StGuard;
            owner_d = lowest(spdt_s_q);
          end else begin
            state_d = StIdle;
            owner_d = 3'b000;
          end
        end else if (state_q == StGuard && bus.tick) begin
          if (gcnt_q == 2'd3) begin
            state_d = StActive;
            gcnt_d  = 2'd0;
          end else begin
            gcnt_d = gcnt_q + 2'd1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        owner_d = 3'b000;
        gcnt_d  = 2'd0;
      end
    endcase
  end

  always_comb begin
    src_word = 16'hFFFF;
    unique case (owner_d)
      3'b001:  src_word = bus.num1;
      3'b010:  src_word = bus.num2;
      3'b100:  src_word = bus.num3;
      default: src_word = 16'hFFFF;
    endcase
  end

  // Display follows the next state so blanking and source switch with the state register.
  always_comb begin
    idx_d      = bus.tick ? idx_q + 2'd1 : idx_q;
    anode_d    = anode_q;
    digit_d    = digit_q;
    push_out_d = 3'b000;
    if (state_d != StActive) begin
      anode_d = 4'b1111;
      digit_d = 4'hF;
    end else if (bus.tick) begin
      anode_d = ~(4'b0001 << idx_q);
      digit_d = src_word[{idx_q, 2'b00} +: 4];
    end
    if (push_rise && state_q == StActive && state_d == StActive) begin
      push_out_d = owner_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      owner_q    <= 3'b000;
      gcnt_q     <= 2'd0;
      idx_q      <= 2'd0;
      anode_q    <= 4'b1111;
      digit_q    <= 4'hF;
      push_out_q <= 3'b000;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      gcnt_q     <= gcnt_d;
      idx_q      <= idx_d;
      anode_q    <= anode_d;
      digit_q    <= digit_d;
      push_out_q <= push_out_d;
    end
  end

  assign bus.grant    = (state_q == StActive) ? owner_q : 3'b000;
  assign bus.push_out = push_out_q;
  assign bus.anode    = anode_q;
  assign bus.digit    = digit_q;

endmodule

// File: tb/tb_service_arbiter.sv
// Directed bench for service_arbiter: table of single-request hand-overs plus sequences for
// scanning, button routing, no pre-emption, guard restart, guard button drop and async reset.
module tb_service_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   total  = 0;
  int   passed = 0;

  service_arbiter_if bus ();

  service_arbiter dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] spdt;
    logic [2:0] exp_grant;
    logic [3:0] exp_dig3;
    logic [3:0] exp_dig0;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tk();
    bus.tick = 1'b1;
    cyc();
    bus.tick = 1'b0;
  endtask

  task automatic do_reset();
    bus.spdt   = 3'b000;
    bus.push_m = 1'b0;
    reset      = 1'b0;
    cyc(2);
    reset = 1'b1;
    cyc();
  endtask

  task automatic req(input logic [2:0] v);
    bus.spdt = v;
    cyc(4);
  endtask

  // Hold/press the button for n cycles, counting owner pulses and any stray bits.
  task automatic watch(input int n, input logic [2:0] want, output int hits, output int stray);
    hits  = 0;
    stray = 0;
    repeat (n) begin
      cyc();
      if (bus.push_out == want && want != 3'b000) hits++;
      else if (bus.push_out != 3'b000) stray++;
    end
  endtask

  initial begin
    logic [3:0] exp_an[4];
    logic [3:0] exp_dg[4];
    int hits, stray;

    bus.tick   = 1'b0;
    bus.spdt   = 3'b000;
    bus.push_m = 1'b0;
    bus.num1   = 16'h9357;
    bus.num2   = 16'h2468;
    bus.num3   = 16'h1234;
    reset      = 1'b0;

    vecs[0] = '{3'b100, 3'b100, 4'h1, 4'h4};
    vecs[1] = '{3'b010, 3'b010, 4'h2, 4'h8};
    vecs[2] = '{3'b001, 3'b001, 4'h9, 4'h7};
    vecs[3] = '{3'b111, 3'b001, 4'h9, 4'h7};
    vecs[4] = '{3'b110, 3'b010, 4'h2, 4'h8};
    vecs[5] = '{3'b011, 3'b001, 4'h9, 4'h7};
    vecs[6] = '{3'b101, 3'b001, 4'h9, 4'h7};

    do_reset();
    chk("reset_grant", 16'(bus.grant), 16'h0);
    chk("reset_push_out", 16'(bus.push_out), 16'h0);
    chk("reset_anode", 16'(bus.anode), 16'hF);
    chk("reset_digit", 16'(bus.digit), 16'hF);

    // Each vector starts from reset, so the scan index is 3 on the granting tick.
    foreach (vecs[i]) begin
      do_reset();
      req(vecs[i].spdt);
      repeat (3) tk();
      chk("guard_grant", 16'(bus.grant), 16'h0);
      chk("guard_anode", 16'(bus.anode), 16'hF);
      tk();
      chk("grant", 16'(bus.grant), 16'(vecs[i].exp_grant));
      chk("anode_idx3", 16'(bus.anode), 16'h7);
      chk("digit_idx3", 16'(bus.digit), 16'(vecs[i].exp_dig3));
      tk();
      chk("anode_idx0", 16'(bus.anode), 16'hE);
      chk("digit_idx0", 16'(bus.digit), 16'(vecs[i].exp_dig0));
    end

    // Full scan of service 3's word.
    do_reset();
    req(3'b100);
    repeat (4) tk();
    exp_an = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    exp_dg = '{4'h4, 4'h3, 4'h2, 4'h1};
    for (int k = 0; k < 4; k++) begin
      tk();
      chk("scan_anode", 16'(bus.anode), 16'(exp_an[k]));
      chk("scan_digit", 16'(bus.digit), 16'(exp_dg[k]));
    end

    // Held button gives a single pulse to the owner only.
    bus.push_m = 1'b1;
    watch(50, 3'b100, hits, stray);
    bus.push_m = 1'b0;
    cyc(4);
    chk("push_pulse_count", 16'(hits), 16'd1);
    chk("push_stray_bits", 16'(stray), 16'd0);

    // No pre-emption, then hand-over through guard on owner release.
    req(3'b101);
    cyc(4);
    chk("no_preempt_grant", 16'(bus.grant), 16'h4);
    req(3'b001);
    chk("handover_guard_grant", 16'(bus.grant), 16'h0);
    chk("handover_guard_anode", 16'(bus.anode), 16'hF);
    repeat (3) tk();
    chk("handover_guard3_anode", 16'(bus.anode), 16'hF);
    chk("handover_guard3_grant", 16'(bus.grant), 16'h0);
    tk();
    chk("handover_grant", 16'(bus.grant), 16'h1);

    // All switches off returns to idle; pending-owner change restarts the guard count.
    req(3'b000);
    chk("release_idle_grant", 16'(bus.grant), 16'h0);
    chk("release_idle_anode", 16'(bus.anode), 16'hF);
    req(3'b100);
    repeat (2) tk();
    req(3'b010);
    repeat (3) tk();
    chk("restart_guard_grant", 16'(bus.grant), 16'h0);
    tk();
    chk("restart_grant", 16'(bus.grant), 16'h2);

    // Button pressed during guard is dropped and never delivered late.
    req(3'b000);
    req(3'b001);
    repeat (2) tk();
    bus.push_m = 1'b1;
    watch(8, 3'b000, hits, stray);
    chk("guard_press_dropped", 16'(stray), 16'd0);
    repeat (2) tk();
    chk("guard_press_grant", 16'(bus.grant), 16'h1);
    watch(10, 3'b000, hits, stray);
    chk("no_late_pulse", 16'(stray), 16'd0);
    bus.push_m = 1'b0;
    cyc(3);
    bus.push_m = 1'b1;
    watch(6, 3'b001, hits, stray);
    bus.push_m = 1'b0;
    chk("fresh_press_pulse", 16'(hits), 16'd1);
    chk("fresh_press_stray", 16'(stray), 16'd0);

    // Asynchronous reset between clock edges while active.
    tk();
    chk("pre_reset_grant", 16'(bus.grant), 16'h1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("async_reset_grant", 16'(bus.grant), 16'h0);
    chk("async_reset_anode", 16'(bus.anode), 16'hF);
    chk("async_reset_digit", 16'(bus.digit), 16'hF);
    cyc(2);
    reset = 1'b1;
    cyc(4);
    repeat (3) tk();
    chk("post_reset_guard_grant", 16'(bus.grant), 16'h0);
    tk();
    chk("post_reset_grant", 16'(bus.grant), 16'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/service_arbiter.md
SERVICE_ARBITER -- requirements
Module: service_arbiter

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset; 0 forces the reset state immediately, regardless of clk.
REQ-003 SHALL have port tick, input, 1, single-cycle display-scan enable (about 1 kHz), sampled on clk.
REQ-004 SHALL have port spdt, input, 3, service request switches: bit0 = service 1 (clock), bit1 = service 2 (alarm), bit2 = service 3 (stopwatch); asynchronous levels.
REQ-005 SHALL have port push_m, input, 1, raw middle push button; asynchronous level.
REQ-006 SHALL have ports num1, num2, num3, input, 16 each, 4-digit BCD display words from services 1-3; digit 0 = bits [3:0].
REQ-007 SHALL have port grant, output, 3, one-hot owner of display and button; 000 = none.
REQ-008 SHALL have port push_out, output, 3, one-cycle button pulse routed to the owner's bit only.
REQ-009 SHALL have port anode, output, 4, active-low digit enable, at most one bit low.
REQ-010 SHALL have port digit, output, 4, BCD nibble for the enabled digit; 4'hF = blank code.

Function
REQ-011 SHALL pass spdt and push_m each through a 2-flop synchronizer before use; synchronized values are spdt_s and push_s.
REQ-012 SHALL implement FSM states IDLE, ACTIVE and GUARD.
REQ-013 IDLE: grant = 000; if spdt_s != 0, SHALL go to GUARD with the pending owner equal to the lowest set spdt_s bit (fixed priority 1 > 2 > 3).
REQ-014 ACTIVE: owner is locked; a newly raised higher-priority switch SHALL NOT pre-empt the owner.
REQ-015 ACTIVE: when the owner's spdt_s bit clears, SHALL go to GUARD with the lowest remaining set bit as pending owner, or go to IDLE if no bits are set.
REQ-016 GUARD: grant = 000 and display blanked; SHALL count 4 tick pulses, then go to ACTIVE with grant = pending owner one-hot.
REQ-017 GUARD: if the pending owner's bit clears before the count completes, SHALL re-evaluate the pending owner per REQ-013 and restart the count from 0; if no bits are set, SHALL go to IDLE.
REQ-018 SHALL detect a rising edge of push_s (current 1, previous 0) and assert push_out[owner] for exactly one clk cycle in the cycle after detection.
REQ-019 SHALL drop button edges detected in IDLE or GUARD; edges are never queued.
REQ-020 A held button SHALL produce only one pulse.
REQ-021 SHALL keep a 2-bit scan index that increments on each tick and wraps from 3 to 0; it runs in every state.
REQ-022 ACTIVE: anode SHALL have bit[index] = 0 and all other bits 1; digit SHALL be nibble[index] of the owner's num word; both are registered, updating one cycle after tick.
REQ-023 IDLE and GUARD: anode SHALL be 4'b1111 and digit SHALL be 4'hF.
REQ-024 When tick coincides with a state transition, the new state's blanking or source rules SHALL apply from the next registered update.

Reset
REQ-025 On reset = 0 SHALL force: state IDLE, grant 000, push_out 000, anode 4'b1111, digit 4'hF, scan index 0, guard count 0, synchronizers and edge history 0.
REQ-026 Reset asserted mid-operation SHALL abort any ACTIVE or GUARD state immediately.
REQ-027 After reset = 1, the first grant SHALL take at least 2 synchronizer cycles plus 4 ticks.

Verification
REQ-028 Owner takes display: spdt=100, wait 4 ticks -> grant=100; num3=16'h1234 -> digit cycles 4,3,2,1 with anode 1110,1101,1011,0111.
REQ-029 Button routing: owner service 3, push_m pulsed high for 50 cycles -> push_out=100 for exactly 1 cycle; push_out bits 0 and 1 stay 0.
REQ-030 No pre-emption: owner service 3, raise spdt bit0 -> grant stays 100; clear bit2 -> GUARD with anode 1111 for 4 ticks, then grant=001.
REQ-031 Guard drop: press push_m while in GUARD -> no push_out pulse; after grant is given, no late pulse appears.
REQ-032 Simultaneous request: spdt 000 -> 111 in the same cycle -> grant=001 after the guard period.
REQ-033 Async reset: assert reset=0 between clk edges while ACTIVE -> grant=000 and anode=1111 immediately, without waiting for a clk edge.
